// File: rtl/id_hazard_controller.sv
// ID-stage hazard unit: shadows downstream write-back bookkeeping,
// raises load-use stalls and selects qa/qb forwarding sources.
module id_hazard_controller #(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   freeze,
   input  logic [4:0]             rs,
   input  logic [4:0]             rt,
   input  logic                   uses_rs,
   input  logic                   uses_rt,
   input  logic                   write_reg,
   input  logic                   mem_to_reg,
   input  logic [4:0]             reg_dest,
   output logic                   stall,
   output logic                   bubble,
   output logic [1:0]             fwd_a,
   output logic [1:0]             fwd_b,
   output logic [STALL_CNT_W-1:0] stall_count
);

   typedef struct packed {
      logic       wr;
      logic       ld;
      logic [4:0] dst;
   } rec_t;

   // The WB record is kept for bookkeeping visibility only: the register
   // file writes in the first half-cycle, so nothing downstream reads it.
   rec_t exe_q, mem_q, wb_q;

   function automatic logic hit(rec_t s, logic [4:0] r);
      return s.wr && (s.dst == r) && (r != 5'd0);
   endfunction

   // A load still in EXE yields 00: that cycle is a bubble anyway.
   function automatic logic [1:0] sel(logic used, logic [4:0] r,
                                      rec_t e, rec_t m);
      logic [1:0] f;
      f = 2'b00;
      if (used) begin
         if (hit(e, r))
            f = e.ld ? 2'b00 : 2'b01;
         else if (hit(m, r))
            f = m.ld ? 2'b11 : 2'b10;
      end
      return f;
   endfunction

   always_comb begin
      stall = exe_q.ld && exe_q.wr &&
              ((uses_rs && hit(exe_q, rs)) ||
               (uses_rt && hit(exe_q, rt)));
      bubble = stall;
      fwd_a  = sel(uses_rs, rs, exe_q, mem_q);
      fwd_b  = sel(uses_rt, rt, exe_q, mem_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         exe_q       <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_count <= '0;
      end else if (!freeze) begin
         if (bubble)
            exe_q <= '0;
         else
            exe_q <= '{wr: write_reg, ld: mem_to_reg, dst: reg_dest};
         mem_q <= exe_q;
         wb_q  <= mem_q;
         if (stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
      end
   end

   logic unused_wb;
   assign unused_wb = ^wb_q;

endmodule

// File: doc/id_hazard_controller.md
Name: id_hazard_controller

Overview:
- Sequences the ID/EXE pipeline register of the 5-stage MIPS datapath.
- Shadows the write-back bookkeeping (write_reg, mem_to_reg, reg_dest) of the EXE, MEM and WB stages.
- From that state it detects load-use hazards and produces stall/bubble controls and the ID-stage forwarding selects for qa/qb.
- Keeps a saturating count of stall cycles for performance debug.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- freeze  in  1  global pipeline hold (e.g. memory wait); pipeline shadow state does not advance.
- rs  in  5  ID-stage source register number.
- rt  in  5  ID-stage target register number.
- uses_rs  in  1  ID instruction reads rs.
- uses_rt  in  1  ID instruction reads rt.
- write_reg  in  1  ID instruction writes a register.
- mem_to_reg  in  1  ID instruction is a load.
- reg_dest  in  5  ID instruction destination register.
- stall  out  1  hold PC and IF/ID register this cycle.
- bubble  out  1  force write_reg/write_mem/mem_to_reg to 0 at ID/EXE input this cycle.
- fwd_a  out  2  qa source: 00 register file, 01 EXE ALU result, 10 MEM ALU result, 11 MEM load data.
- fwd_b  out  2  qb source, same encoding as fwd_a.
- stall_count  out  STALL_CNT_W  saturating count of stall cycles since reset.

Behaviour:
- Shadow state: three stage records (EXE, MEM, WB), each {wr, ld, dst[4:0]}.
- Stage records advance on posedge clk when freeze=0:
  - EXE <= bubble ? {0,0,0} : {write_reg, mem_to_reg, reg_dest}.
  - MEM <= EXE.
  - WB <= MEM.
- freeze=1: all records and stall_count hold. Outputs are still computed combinationally from the held state.
- A record "matches" register r when wr=1, dst==r and r!=0. Register $0 never produces a hazard or a forward.
- Load-use stall is combinational:
  - stall = (EXE.ld && EXE.wr && ((uses_rs && EXE matches rs) || (uses_rt && EXE matches rt))).
  - bubble = stall.
  - freeze does not mask stall.
- Forward select for a used operand r (fwd_a for rs, fwd_b for rt), highest priority first:
  - EXE matches r and EXE.ld=0 -> 01.
  - else MEM matches r -> 11 if MEM.ld=1, else 10.
  - else -> 00.
  - Unused operand -> 00.
  - WB is not forwarded; the register file writes in the first half-cycle.
  - An EXE load match yields 00 together with stall=1. The ID/EXE value is discarded by the bubble.
- Stall sequencing: after a one-cycle stall the load moves to MEM and the held ID instruction sees a MEM match, giving fwd=11 and stall=0. A load-use hazard therefore costs exactly one cycle.
- Back-to-back loads into the same consumer each cost one stall, independently.
- stall_count increments by 1 on each posedge with stall=1, freeze=0 and reset=0. It saturates at all-ones.
- Reset: all stage records, including stall_count, clear to 0 on the posedge where reset=1. Reset overrides freeze.
- After reset: stall=0, bubble=0, fwd_a=00, fwd_b=00, stall_count=0.
- Reset mid-stall: stall drops in the cycle after the reset edge, because EXE is now cleared.
- Latency:
  - stall, bubble and fwd_* are combinational (0 cycles) from the ID inputs and current state.
  - State reflects an ID instruction 1 cycle later (EXE), 2 cycles later (MEM) and 3 cycles later (WB).

Test Plan:
- Load-use: `lw $5` (write_reg=1, mem_to_reg=1, dst=5), then `add` using rs=5.
  - Cycle 1: stall=1, bubble=1, fwd_a=00.
  - Cycle 2: stall=0, fwd_a=11.
  - stall_count=1.
- ALU chain: `add $3`, then `sub` with rs=3, rt=3.
  - fwd_a=fwd_b=01, stall=0.
  - Next instruction with rs=3: fwd_a=10.
- Priority and $0:
  - `add $4` ; `add $4` ; consumer rs=4 -> fwd_a=01 (EXE beats MEM).
  - Any producer with dst=0 and consumer rs=0 -> fwd_a=00, stall=0.
- Freeze: assert freeze during a load-use stall for 3 cycles.
  - stall stays 1 and stall_count does not change.
  - On release: one counted stall, then fwd_a=11.
- Reset mid-stall: reset=1 on the stall cycle.
  - Next cycle: stall=0, fwd_a=fwd_b=00, stall_count=0.
- Saturation: with STALL_CNT_W=2, run 5 consecutive load-use pairs -> stall_count=3 and holds.
